// File: rtl/alu_self_check_pkg.sv
// alu_self_check_pkg: op encodings, table sizing and FSM states shared by the ALU self-checker.
package alu_self_check_pkg;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;
  localparam int NUM_VECTORS_DEF = 11;
  localparam int DW = 4;
  localparam int OW = 3;
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_e;
endpackage

// File: rtl/alu_vec_rom.sv
// alu_vec_rom: combinational stimulus table of operands and expected ALU responses.
module alu_vec_rom
  import alu_self_check_pkg::*;
(
  input  logic [3:0]    idx_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic          ci_o,
  output logic [OW-1:0] op_o,
  output logic [DW-1:0] exp_r_o,
  output logic          exp_flag_o
);
  // exp_flag is the expected slt for OP_SLT and the expected carry-out otherwise
  always_comb begin
    {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = '0;
    case (idx_i)
      4'd0:  {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd4,  4'd2,  1'b0, OP_ADD, 4'd6,  1'b0};
      4'd1:  {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd5,  4'd2,  1'b1, OP_SUB, 4'd3,  1'b1};
      4'd2:  {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd2,  4'd4,  1'b1, OP_SUB, 4'd14, 1'b0};
      4'd3:  {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd2,  4'd3,  1'b1, OP_SUB, 4'd15, 1'b0};
      4'd4:  {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd2,  4'd7,  1'b1, OP_SLT, 4'd11, 1'b1};
      4'd5:  {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd4,  4'd4,  1'b1, OP_SLT, 4'd0,  1'b0};
      4'd6:  {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd5,  4'd4,  1'b1, OP_SLT, 4'd1,  1'b0};
      4'd7:  {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd15, 4'd0,  1'b1, OP_SLT, 4'd15, 1'b1};
      4'd8:  {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd12, 4'd12, 1'b1, OP_SLT, 4'd0,  1'b0};
      4'd9:  {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd1,  4'd1,  1'b0, OP_AND, 4'd1,  1'b0};
      4'd10: {a_o, b_o, ci_o, op_o, exp_r_o, exp_flag_o} = {4'd1,  4'd0,  1'b0, OP_OR,  4'd1,  1'b0};
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_self_check.sv
// alu_self_check: walks the vector table through an external 4-bit ALU and tallies pass/fail.
module alu_self_check
  import alu_self_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_VECTORS   = NUM_VECTORS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_ci,
  output logic [OW-1:0] alu_op,
  input  logic [DW-1:0] alu_r,
  input  logic          alu_co,
  input  logic          alu_slt,
  output logic          busy,
  output logic          done,
  output logic [3:0]    pass_cnt,
  output logic [3:0]    fail_cnt,
  output logic [3:0]    first_fail_idx,
  output logic          fail_seen
);
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] IDX_LAST = 4'(NUM_VECTORS - 1);
  state_e state_q, state_d;
  logic [3:0] idx_q;
  logic [7:0] cnt_q;
  logic [DW-1:0] v_a, v_b, v_r;
  logic [OW-1:0] v_op;
  logic v_ci, v_flag, match;
  alu_vec_rom u_rom (
    .idx_i     (idx_q),
    .a_o       (v_a),
    .b_o       (v_b),
    .ci_o      (v_ci),
    .op_o      (v_op),
    .exp_r_o   (v_r),
    .exp_flag_o(v_flag)
  );
  assign match = (alu_r == v_r) && (((alu_op == OP_SLT) ? alu_slt : alu_co) == v_flag);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = start ? S_DRIVE : S_IDLE;
      S_DRIVE:  state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
      S_SETTLE: state_d = (cnt_q == CNT_LAST) ? S_CHECK : S_SETTLE;
      S_CHECK:  state_d = (idx_q == IDX_LAST) ? S_DONE : S_DRIVE;
      default:  state_d = S_IDLE;
    endcase
  end
  // busy/done lag the state by one edge so every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      {idx_q, cnt_q, busy, done, pass_cnt, fail_cnt, first_fail_idx, fail_seen} <= '0;
      {alu_a, alu_b, alu_ci, alu_op} <= '0;
    end else begin
      state_q <= state_d;
      done    <= state_q == S_DONE;
      busy    <= (state_q == S_IDLE) ? start : state_q != S_DONE;
      if (state_q == S_IDLE && start) begin
        {idx_q, pass_cnt, fail_cnt, first_fail_idx, fail_seen} <= '0;
      end
      if (state_q == S_DRIVE) begin
        {alu_a, alu_b, alu_ci, alu_op} <= {v_a, v_b, v_ci, v_op};
        cnt_q <= '0;
      end
      if (state_q == S_SETTLE) cnt_q <= cnt_q + 8'd1;
      if (state_q == S_CHECK) begin
        if (match) pass_cnt <= pass_cnt + 4'd1;
        else begin
          fail_cnt <= fail_cnt + 4'd1;
          if (!fail_seen) begin
            first_fail_idx <= idx_q;
            fail_seen      <= 1'b1;
          end
        end
        if (idx_q != IDX_LAST) idx_q <= idx_q + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_self_check.sv
// tb_alu_self_check: directed runs of the self-checker against a behavioural ALU with injectable faults.
module tb_alu_self_check;
  import alu_self_check_pkg::*;
  logic clk = 0, reset = 1, start0 = 0, start1 = 0;
  logic [3:0] a0, b0, r0, pc0, fc0, ffi0, a1, b1, r1, pc1, fc1, ffi1;
  logic [2:0] op0, op1;
  logic ci0, co0, slt0, busy0, done0, fs0, ci1, co1, slt1, busy1, done1, fs1;
  bit f_sub_co = 0, f_slt0 = 0;
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  function automatic logic [5:0] alu(input logic [3:0] a, b, input logic ci, input logic [2:0] op,
                                     input bit fsub, fslt);
    logic [4:0] s;
    logic [3:0] bb, r;
    logic co, lt;
    bb = (op == OP_SUB || op == OP_SLT) ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + 5'(ci);
    r  = (op == OP_AND) ? (a & b) : (op == OP_OR) ? (a | b) : s[3:0];
    co = (op == OP_AND || op == OP_OR) ? 1'b0 : s[4];
    lt = $signed(a) < $signed(b);
    if (fsub && op == OP_SUB) co = ~co;
    if (fslt) lt = 1'b0;
    return {co, lt, r};
  endfunction
  assign {co0, slt0, r0} = alu(a0, b0, ci0, op0, f_sub_co, f_slt0);
  assign {co1, slt1, r1} = alu(a1, b1, ci1, op1, 1'b0, 1'b0);
  alu_self_check u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .alu_a(a0), .alu_b(b0), .alu_ci(ci0), .alu_op(op0),
    .alu_r(r0), .alu_co(co0), .alu_slt(slt0), .busy(busy0), .done(done0), .pass_cnt(pc0),
    .fail_cnt(fc0), .first_fail_idx(ffi0), .fail_seen(fs0)
  );
  alu_self_check #(.SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .alu_a(a1), .alu_b(b1), .alu_ci(ci1), .alu_op(op1),
    .alu_r(r1), .alu_co(co1), .alu_slt(slt1), .busy(busy1), .done(done1), .pass_cnt(pc1),
    .fail_cnt(fc1), .first_fail_idx(ffi1), .fail_seen(fs1)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // cycles counted from the accepting edge to the first sample with done high
  task automatic run(input bit which, input bit repulse, output int n);
    if (which) start1 = 1; else start0 = 1;
    @(posedge clk);
    #1 start0 = 0;
    start1 = 0;
    n = 0;
    while (n < 200) begin
      start0 = repulse && (n == 10 || n == 30);
      @(posedge clk);
      n++;
      #1;
      if (which ? done1 : done0) break;
    end
    start0 = 0;
  endtask
  initial begin
    int dn;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_cnts", {pc0, fc0, ffi0}, 0);
    check("rst_seen", fs0, 0);
    check("rst_drive", {a0, b0, ci0, op0}, 0);
    reset = 0;
    run(0, 0, cyc);
    check("good_cycles", cyc, 45);
    check("good_pass", pc0, 11);
    check("good_fail", fc0, 0);
    check("good_seen", fs0, 0);
    check("good_busy_at_done", busy0, 0);
    check("hold_drive", {a0, b0, ci0, op0}, {4'd1, 4'd0, 1'b0, 3'd1});
    repeat (5) @(posedge clk);
    #1;
    check("hold_pass", pc0, 11);
    check("done_one_cycle", done0, 0);
    f_sub_co = 1;
    run(0, 0, cyc);
    check("subco_pass", pc0, 8);
    check("subco_fail", fc0, 3);
    check("subco_first", ffi0, 1);
    check("subco_seen", fs0, 1);
    f_sub_co = 0;
    f_slt0 = 1;
    run(0, 0, cyc);
    check("slt0_pass", pc0, 9);
    check("slt0_fail", fc0, 2);
    check("slt0_first", ffi0, 4);
    f_slt0 = 0;
    run(0, 1, cyc);
    check("repulse_cycles", cyc, 45);
    check("repulse_pass", pc0, 11);
    start0 = 1;
    @(posedge clk);
    #1 start0 = 0;
    repeat (22) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    check("abort_busy", busy0, 0);
    check("abort_cnts", {pc0, fc0, ffi0, fs0}, 0);
    check("abort_drive", {a0, b0, ci0, op0}, 0);
    dn = 0;
    repeat (60) begin
      @(posedge clk);
      #1 dn += int'(done0);
    end
    check("abort_no_done", dn, 0);
    run(0, 0, cyc);
    check("after_abort_cycles", cyc, 45);
    check("after_abort_pass", pc0, 11);
    run(1, 0, cyc);
    check("s0_cycles", cyc, 23);
    check("s0_pass", pc1, 11);
    check("s0_fail", fc1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
